// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and Memoria bus for mem_port_arbiter.
// slave: the arbiter side. master: the requesters plus the memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvalid;
  // data (load/store) requester
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  // Memoria port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rdata, if_rvalid, d_gnt, d_rdata, d_done,
           mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rdata, if_rvalid, d_gnt, d_rdata, d_done,
           mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port Memoria arbiter/sequencer for the multicycle datapath.
// Grants fetch or data access one at a time, holds the memory bus for
// MEM_LAT cycles, then returns the word with a one-cycle completion pulse.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  mem_port_arbiter_if.slave bus,
  output logic       busy,
  output logic [1:0] state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  logic [3:0] cnt;
  logic       last_data;   // 1: data requester owned the most recent grant
  logic       owner_data;  // owner of the access in flight
  logic       owner_wr;    // access in flight is a store
  logic       pick_data;

  // Data wins when alone, or on a tie when fetch was served last.
  always_comb begin
    pick_data = 1'b0;
    if (bus.d_req && bus.if_req) pick_data = !last_data;
    else if (bus.d_req)          pick_data = 1'b1;
  end

  // Sequencer: arbitrate in IDLE, count latency in BUSY, pulse in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      cnt           <= '0;
      last_data     <= 1'b1;
      owner_data    <= 1'b0;
      owner_wr      <= 1'b0;
      bus.if_gnt    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.if_rvalid <= 1'b0;
      bus.d_gnt     <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_done    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wr    <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      // all pulses default low; only the cases below raise them
      bus.if_gnt    <= 1'b0;
      bus.d_gnt     <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.d_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            state      <= BUSY;
            busy       <= 1'b1;
            cnt        <= CNT_INIT;
            owner_data <= pick_data;
            last_data  <= pick_data;
            if (pick_data) begin
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
              bus.mem_wr    <= bus.d_wr;
              owner_wr      <= bus.d_wr;
              bus.d_gnt     <= 1'b1;
            end else begin
              bus.mem_addr  <= bus.if_addr;
              owner_wr      <= 1'b0;
              bus.if_gnt    <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= RESP;
            if (owner_data) begin
              bus.d_done <= 1'b1;
              if (!owner_wr) bus.d_rdata <= bus.mem_rdata;
            end else begin
              bus.if_rvalid <= 1'b1;
              bus.if_rdata  <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model,
// plus a short directed sequence on a MEM_LAT=1 instance.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  logic       busy, busy1;
  logic [1:0] state, state1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .state(state)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .busy(busy1), .state(state1)
  );

  // Memoria behavioural model: 8 words selected by address bits [4:2]
  function automatic logic [31:0] init_word(input int j);
    return 32'h8C22_0000 + 32'(j) * 32'h0000_0101;
  endfunction

  logic [31:0] phys_mem [8];
  bit          mem_ready = 1'b0;
  assign bus.mem_rdata  = phys_mem[bus.mem_addr[4:2]];
  assign bus1.mem_rdata = {16'hA5A5, bus1.mem_addr[15:0]};

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int j = 0; j < 8; j++) phys_mem[j] <= init_word(j);
      mem_ready <= 1'b1;
    end else if (bus.mem_wr) begin
      phys_mem[bus.mem_addr[4:2]] <= bus.mem_wdata;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // Transaction-level reference: one access at a time, started at edge g.
  int          cyc;
  bit          act;
  int          g;
  bit          own_d, own_wr, last_d;
  logic [31:0] t_addr, t_wdata;
  logic [31:0] e_if_rdata, e_d_rdata;
  logic [31:0] ref_mem [8];
  int          resets_left;

  task automatic model_reset();
    act = 1'b0; last_d = 1'b1; own_d = 1'b0; own_wr = 1'b0;
    t_addr = '0; t_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
  endtask

  // Advance the model over the rising edge that began cycle cyc.
  task automatic model_edge();
    if (act && own_d && own_wr && cyc == g + 1) ref_mem[t_addr[4:2]] = t_wdata;
    if (act && cyc == g + LAT) begin
      if (!own_d) e_if_rdata = ref_mem[t_addr[4:2]];
      else if (!own_wr) e_d_rdata = ref_mem[t_addr[4:2]];
    end
    if ((!act || cyc >= g + LAT + 2) && (bus.if_req || bus.d_req)) begin
      if (bus.if_req && bus.d_req) own_d = !last_d;
      else own_d = bus.d_req;
      last_d = own_d;
      act    = 1'b1;
      g      = cyc;
      own_wr = own_d && bus.d_wr;
      t_addr = own_d ? bus.d_addr : bus.if_addr;
      if (own_d) t_wdata = bus.d_wdata;
    end
  endtask

  task automatic check_cycle();
    int k;
    bit in_busy, in_resp;
    k = cyc - g;
    in_busy = act && k >= 0 && k < LAT;
    in_resp = act && k == LAT;
    chk("if_gnt",    32'(bus.if_gnt),    32'(act && k == 0 && !own_d));
    chk("d_gnt",     32'(bus.d_gnt),     32'(act && k == 0 && own_d));
    chk("mem_wr",    32'(bus.mem_wr),    32'(act && k == 0 && own_wr));
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(in_resp && !own_d));
    chk("d_done",    32'(bus.d_done),    32'(in_resp && own_d));
    chk("busy",      32'(busy),          32'(in_busy || in_resp));
    chk("state",     32'(state),         in_busy ? 32'd1 : (in_resp ? 32'd2 : 32'd0));
    chk("mem_addr",  bus.mem_addr,       t_addr);
    chk("if_rdata",  bus.if_rdata,       e_if_rdata);
    chk("d_rdata",   bus.d_rdata,        e_d_rdata);
    if (in_busy && own_wr) chk("mem_wdata", bus.mem_wdata, t_wdata);
  endtask

  // Asynchronous reset in the first BUSY cycle of a store, released mid-cycle.
  task automatic maybe_reset();
    if (resets_left > 0 && act && cyc == g && own_wr && $urandom_range(0, 1) == 1) begin
      resets_left--;
      #1 reset = 1'b0;
      #1;
      chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("rst_busy",   32'(busy),       32'd0);
      chk("rst_state",  32'(state),      32'd0);
      chk("rst_d_done", 32'(bus.d_done), 32'd0);
      #1 reset = 1'b1;
      model_reset();
    end
  endtask

  // Requesters: hold until completion is due, drop, later re-request.
  task automatic agents();
    logic [31:0] a;
    bit in_resp;
    in_resp = act && (cyc - g) == LAT;
    if (bus.if_req) begin
      if (in_resp && !own_d) bus.if_req = 1'b0;
    end else if ($urandom_range(0, 1) == 1) begin
      a = $urandom(); a[1:0] = 2'b00;
      bus.if_req = 1'b1; bus.if_addr = a;
    end
    if (bus.d_req) begin
      if (in_resp && own_d) bus.d_req = 1'b0;
    end else if ($urandom_range(0, 1) == 1) begin
      a = $urandom(); a[1:0] = 2'b00;
      bus.d_req = 1'b1; bus.d_addr = a;
      bus.d_wr = 1'($urandom_range(0, 1)); bus.d_wdata = $urandom();
    end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_wr = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0; bus1.d_wr = 1'b0;
    bus1.d_addr = '0; bus1.d_wdata = '0;
    for (int j = 0; j < 8; j++) ref_mem[j] = init_word(j);
    model_reset();
    resets_left = 3;
    cyc = 0;
    g = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_state",    32'(state),         32'd0);
    chk("reset_busy",     32'(busy),          32'd0);
    chk("reset_mem_addr", bus.mem_addr,       32'd0);
    chk("reset_if_rdata", bus.if_rdata,       32'd0);
    chk("reset_gnt1",     32'(bus1.d_gnt),    32'd0);

    // MEM_LAT=1: load at 0x20, then a store granted in cycle 4
    reset = 1'b1;
    bus1.d_req = 1'b1; bus1.d_wr = 1'b0; bus1.d_addr = 32'h20;
    @(negedge clk);
    chk("l1_c1_d_gnt",    32'(bus1.d_gnt),  32'd1);
    chk("l1_c1_state",    32'(state1),      32'd1);
    chk("l1_c1_mem_addr", bus1.mem_addr,    32'h20);
    chk("l1_c1_mem_wr",   32'(bus1.mem_wr), 32'd0);
    @(negedge clk);
    chk("l1_c2_d_done",   32'(bus1.d_done), 32'd1);
    chk("l1_c2_d_rdata",  bus1.d_rdata,     32'hA5A5_0020);
    chk("l1_c2_state",    32'(state1),      32'd2);
    bus1.d_req = 1'b0;
    @(negedge clk);
    chk("l1_c3_busy",     32'(busy1),       32'd0);
    chk("l1_c3_d_done",   32'(bus1.d_done), 32'd0);
    bus1.d_req = 1'b1; bus1.d_wr = 1'b1; bus1.d_addr = 32'h24; bus1.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("l1_c4_d_gnt",    32'(bus1.d_gnt),  32'd1);
    chk("l1_c4_mem_wr",   32'(bus1.mem_wr), 32'd1);
    chk("l1_c4_wdata",    bus1.mem_wdata,   32'hDEAD_BEEF);
    @(negedge clk);
    chk("l1_c5_d_done",   32'(bus1.d_done), 32'd1);
    chk("l1_c5_d_rdata",  bus1.d_rdata,     32'hA5A5_0020);
    chk("l1_c5_mem_wr",   32'(bus1.mem_wr), 32'd0);
    chk("l1_c5_if_gnt",   32'(bus1.if_gnt), 32'd0);
    bus1.d_req = 1'b0;

    // main randomized run, starting with a tie straight out of reset
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0008;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 32'h0000_0100; bus.d_wdata = '0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      model_edge();
      check_cycle();
      maybe_reset();
      agents();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
